alu16_op_sequencer: RTL and testbench
=====================================

Name: alu16_op_sequencer

Overview:
Command-driven controller that owns the 16-bit ALU datapath (bitwise AND/OR/XOR, add/sub) and sequences single-cycle and multi-cycle operations on it. Upstream logic issues one command at a time over a valid/ready handshake. Multi-cycle ops are built by iterating the shared adder/shift path: multiply by shift-add, and shift-left by repeated single shifts. The registered result and flags are returned over a second valid/ready handshake.

Parameters:
W, 16, datapath width; MUL iterates W times; shift amount field is clog2(W) bits (4 at default)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept command
cmd_op  input  3  opcode: 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101 MUL, 110 SHL, 111 reserved
cmd_a  input  W  operand a
cmd_b  input  W  operand b (SHL: b[3:0] = shift amount)
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_s  output  W  result
res_c  output  1  carry flag
res_z  output  1  zero flag
res_err  output  1  illegal opcode flag
busy  output  1  high in EXEC or ITER

Behaviour:
- Reset (rst_n low at clk edge) forces IDLE, res_valid=0, res_s=0, res_c=0, res_z=0, res_err=0, busy=0, iteration counter=0. Reset applies in any state and aborts an in-flight command with no result produced.
- States: IDLE, EXEC, ITER, DONE. cmd_ready=1 only in IDLE. busy=1 in EXEC and ITER.
- IDLE: on cmd_valid&&cmd_ready, latch op/a/b, go to EXEC. Operands are never resampled after accept.
- EXEC, single-cycle ops (AND/OR/XOR/ADD/SUB/reserved, SHL with amount 0): compute, register result, go to DONE. res_valid rises one edge after the accept edge.
- EXEC, MUL: clear accumulator, load counter=W, go to ITER.
- EXEC, SHL with amount k>0: load counter=k, go to ITER.
- ITER, MUL: each cycle, if multiplier LSB=1 then acc += multiplicand (mod 2^W). Multiplicand shifts left 1, multiplier shifts right 1, counter decrements. When the counter reaches 0, go to DONE. res_s is the low W bits of the product.
- ITER, SHL: shift left 1 per cycle, zero fill, k cycles.
- DONE: res_valid=1. res_* stay stable while res_valid&&!res_ready. On res_valid&&res_ready, go to IDLE. cmd_ready is asserted the following cycle, so there is no same-cycle accept.
- Latency, accept edge to res_valid edge: 1 for single-cycle ops, 1+W for MUL (17), 1+k for SHL.
- Arithmetic: ADD computes {c,s}=a+b. SUB computes s=a-b mod 2^W, with c=1 iff a>=b unsigned (no borrow). MUL c=1 iff any product bit ≥W is nonzero. SHL c = last bit shifted out (0 if k=0). Bitwise ops set c=0.
- z=1 iff res_s==0, valid for every opcode.
- Reserved opcode 111: res_s=0, c=0, z=1, err=1, 1-cycle latency. err=0 for all other opcodes.
- Flags and res_s change only on the edge entering DONE or on reset.

Test Plan:
- Reset, then OR a=0x00F0 b=0x0F00 -> res_s=0x0FF0, c=0, z=0, res_valid one edge after accept. Also AND of same operands -> 0x0000, z=1. Both checks confirm the bitwise ops are not swapped.
- ADD a=0xFFFF b=0x0001 -> res_s=0x0000, c=1, z=1. SUB a=0x0003 b=0x0005 -> res_s=0xFFFE, c=0. SUB a=5 b=3 -> 0x0002, c=1.
- MUL a=0x0012 b=0x0034 -> res_s=0x03A8, c=0, res_valid exactly 17 edges after accept. MUL a=0x0100 b=0x0100 -> res_s=0x0000, c=1, z=1. busy=1 and cmd_ready=0 throughout.
- SHL a=0x0001 b=0x000F -> res_s=0x8000 after 16 edges. SHL a=0x8001 b=0x0001 -> res_s=0x0002, c=1. SHL with b=0 -> res_s=a, 1-cycle latency.
- Backpressure: hold res_ready=0 for 5 cycles after ADD completes -> res_valid and res_s stable, cmd_ready=0, and a new cmd_valid is not accepted. Raise res_ready -> IDLE next edge, cmd_ready=1 the following cycle.
- Drive rst_n=0 for one edge mid-MUL (iteration 8) -> all outputs return to 0 and state returns to IDLE. A following OR command completes normally. Opcode 111 -> res_s=0, err=1, z=1.

Source files
------------

// File: rtl/alu16_op_sequencer.sv
// ============================================================================
// alu16_op_sequencer
//
// Purpose:
//   Command-driven controller that owns a W-bit ALU datapath. It accepts one
//   command at a time, runs it either in a single EXEC cycle (AND/OR/XOR/ADD/
//   SUB/reserved, SHL by 0) or by iterating the shared shift/add path (MUL by
//   shift-add over W cycles, SHL by k single-bit shifts), and holds the
//   registered result and flags until the consumer takes them.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset; aborts any in-flight command
//   cmd_valid  in   command present
//   cmd_ready  out  controller can accept a command (IDLE only)
//   cmd_op     in   3-bit opcode (AND, OR, XOR, ADD, SUB, MUL, SHL, reserved)
//   cmd_a      in   operand a (W bits)
//   cmd_b      in   operand b (W bits); SHL uses the low clog2(W) bits as k
//   res_valid  out  result available (DONE)
//   res_ready  in   consumer accepts result
//   res_s      out  result (W bits)
//   res_c      out  carry flag
//   res_z      out  zero flag (res_s == 0)
//   res_err    out  illegal opcode flag
//   busy       out  high while executing (EXEC or ITER)
// ============================================================================
module alu16_op_sequencer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_s,
    output logic         res_c,
    output logic         res_z,
    output logic         res_err,
    output logic         busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Shift-amount field width and iteration-counter width. The counter must
    // be able to hold W itself (MUL loads W).
    localparam int unsigned SW = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned CW = $clog2(W + 1);

    localparam logic [CW-1:0] CNT_MUL = CW'(W);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]     state_q,   state_d;
    logic [2:0]     op_q,      op_d;
    // mcand holds operand a. It is 2W wide so the MUL shift-add keeps the
    // high half of the product, which is what the MUL carry flag reports.
    // SHL reuses the same register and shift path; only the low W bits and
    // bit W-1 (the next bit to fall out) matter for it.
    logic [2*W-1:0] mcand_q,   mcand_d;
    // mplier holds operand b; MUL shifts it right one bit per iteration.
    logic [W-1:0]   mplier_q,  mplier_d;
    logic [2*W-1:0] acc_q,     acc_d;
    logic [CW-1:0]  cnt_q,     cnt_d;
    logic [W-1:0]   res_s_q,   res_s_d;
    logic           res_c_q,   res_c_d;
    logic           res_z_q,   res_z_d;
    logic           res_err_q, res_err_d;

    // ------------------------------------------------------------------------
    // Single-cycle datapath, working on the latched operands
    // ------------------------------------------------------------------------
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic [W-1:0] and_w;
    logic [W-1:0] or_w;
    logic [W-1:0] xor_w;
    logic [W:0]   add_w;
    logic [W:0]   sub_w;
    logic [SW-1:0] shamt;

    assign opa   = mcand_q[W-1:0];
    assign opb   = mplier_q;
    assign shamt = mplier_q[SW-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < int'(W); gi++) begin : g_bitwise
            assign and_w[gi] = opa[gi] & opb[gi];
            assign or_w[gi]  = opa[gi] | opb[gi];
            assign xor_w[gi] = opa[gi] ^ opb[gi];
        end
    endgenerate

    // One extra bit on each: ADD's top bit is the carry out; SUB's top bit
    // is the borrow, so "no borrow" (a >= b unsigned) is its inverse.
    assign add_w = {1'b0, opa} + {1'b0, opb};
    assign sub_w = {1'b0, opa} - {1'b0, opb};

    logic [W-1:0] exec_s;
    logic         exec_c;
    logic         exec_err;

    always_comb begin
        exec_s   = '0;
        exec_c   = 1'b0;
        exec_err = 1'b0;
        case (op_q)
            OP_AND: exec_s = and_w;
            OP_OR:  exec_s = or_w;
            OP_XOR: exec_s = xor_w;
            OP_ADD: begin
                exec_s = add_w[W-1:0];
                exec_c = add_w[W];
            end
            OP_SUB: begin
                exec_s = sub_w[W-1:0];
                exec_c = ~sub_w[W];
            end
            // SHL reaches this path only with k == 0: result is a, no carry.
            OP_SHL: exec_s = opa;
            // MUL never completes in EXEC; the reserved opcode flags an error
            // with a zero result.
            OP_MUL: exec_s = '0;
            default: exec_err = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------------
    // Iterative datapath: one shift-add (MUL) or one shift (SHL) per cycle
    // ------------------------------------------------------------------------
    logic [2*W-1:0] acc_step;
    logic [2*W-1:0] mcand_shl;
    logic           last_iter;

    assign acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign mcand_shl = {mcand_q[2*W-2:0], 1'b0};
    // The counter never legally sits at 0 in ITER; treating 0 like 1 keeps
    // the machine from wrapping round for 2^CW cycles if it ever did.
    assign last_iter = (cnt_q <= CNT_ONE);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    logic         load_res;
    logic [W-1:0] load_s;
    logic         load_c;
    logic         load_err;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        load_res = 1'b0;
        load_s   = '0;
        load_c   = 1'b0;
        load_err = 1'b0;

        case (state_q)
            S_IDLE: begin
                // cmd_ready is high throughout IDLE, so cmd_valid alone is
                // the handshake here.
                if (cmd_valid) begin
                    op_d     = cmd_op;
                    mcand_d  = {{W{1'b0}}, cmd_a};
                    mplier_d = cmd_b;
                    state_d  = S_EXEC;
                end
            end

            S_EXEC: begin
                if (op_q == OP_MUL) begin
                    acc_d   = '0;
                    cnt_d   = CNT_MUL;
                    state_d = S_ITER;
                end else if ((op_q == OP_SHL) && (shamt != '0)) begin
                    cnt_d   = CW'(shamt);
                    state_d = S_ITER;
                end else begin
                    load_res = 1'b1;
                    load_s   = exec_s;
                    load_c   = exec_c;
                    load_err = exec_err;
                    state_d  = S_DONE;
                end
            end

            S_ITER: begin
                cnt_d   = cnt_q - CNT_ONE;
                mcand_d = mcand_shl;
                if (op_q == OP_MUL) begin
                    acc_d    = acc_step;
                    mplier_d = {1'b0, mplier_q[W-1:1]};
                end
                if (last_iter) begin
                    // Result is taken straight from this cycle's step so it
                    // lands in the result registers on the edge into DONE.
                    load_res = 1'b1;
                    state_d  = S_DONE;
                    if (op_q == OP_MUL) begin
                        load_s = acc_step[W-1:0];
                        load_c = |acc_step[2*W-1:W];
                    end else begin
                        load_s = mcand_shl[W-1:0];
                        load_c = mcand_q[W-1];
                    end
                end
            end

            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Result and flags move only on the edge that enters DONE.
        res_s_d   = load_res ? load_s           : res_s_q;
        res_c_d   = load_res ? load_c           : res_c_q;
        res_z_d   = load_res ? (load_s == '0)   : res_z_q;
        res_err_d = load_res ? load_err         : res_err_q;
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            res_s_q   <= '0;
            res_c_q   <= 1'b0;
            res_z_q   <= 1'b0;
            res_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            res_s_q   <= res_s_d;
            res_c_q   <= res_c_d;
            res_z_q   <= res_z_d;
            res_err_q <= res_err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign cmd_ready = (state_q == S_IDLE);
    assign res_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_EXEC) || (state_q == S_ITER);
    assign res_s     = res_s_q;
    assign res_c     = res_c_q;
    assign res_z     = res_z_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_alu16_op_sequencer.sv
// ============================================================================
// tb_alu16_op_sequencer
//
// Directed testbench for alu16_op_sequencer. Each command is issued over the
// cmd handshake, the latency to res_valid is counted, and the result, flags,
// busy/cmd_ready behaviour and the return to IDLE are compared against
// hand-computed values. One line is printed per transaction.
// ============================================================================
module tb_alu16_op_sequencer;

    localparam int W = 16;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_RSV = 3'b111;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_op    = 3'b000;
    logic [W-1:0] cmd_a     = '0;
    logic [W-1:0] cmd_b     = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_s;
    logic         res_c;
    logic         res_z;
    logic         res_err;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    alu16_op_sequencer #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_s     (res_s),
        .res_c     (res_c),
        .res_z     (res_z),
        .res_err   (res_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Watchdog: the directed sequence is short; this only guards a hang.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven and
    // outputs sampled at this point, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command and hold it across the accept edge.
    task automatic start(input string tag, input logic [2:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        int w;
        w = 0;
        while (!cmd_ready && w < 50) begin
            tick();
            w++;
        end
        check({tag, " cmd_ready_before_accept"}, 32'(cmd_ready), 32'd1);
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check({tag, " busy_after_accept"}, 32'(busy), 32'd1);
    endtask

    // Wait for the result, compare it, optionally consume it.
    task automatic finish_op(input string tag, input logic [W-1:0] exp_s,
                             input logic exp_c, input logic exp_z, input logic exp_err,
                             input int exp_lat, input bit consume);
        int  n;
        bit  bad;
        n   = 0;
        bad = 1'b0;
        while (!res_valid && n < 40) begin
            if (!busy || cmd_ready) bad = 1'b1;
            tick();
            n++;
        end
        check({tag, " latency"},   32'(n),         32'(exp_lat));
        check({tag, " res_valid"}, 32'(res_valid), 32'd1);
        check({tag, " res_s"},     32'(res_s),     32'(exp_s));
        check({tag, " res_c"},     32'(res_c),     32'(exp_c));
        check({tag, " res_z"},     32'(res_z),     32'(exp_z));
        check({tag, " res_err"},   32'(res_err),   32'(exp_err));
        check({tag, " busy_cmd_ready_while_running"}, 32'(bad), 32'd0);
        check({tag, " busy_in_done"}, 32'(busy), 32'd0);
        $display("TXN %-10s s=0x%04h c=%0b z=%0b err=%0b latency=%0d",
                 tag, res_s, res_c, res_z, res_err, n);
        if (consume) begin
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            check({tag, " res_valid_after_take"}, 32'(res_valid), 32'd0);
            check({tag, " cmd_ready_after_take"}, 32'(cmd_ready), 32'd1);
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_s, input logic exp_c,
                         input logic exp_z, input logic exp_err, input int exp_lat);
        start(tag, op, a, b);
        finish_op(tag, exp_s, exp_c, exp_z, exp_err, exp_lat, 1'b1);
    endtask

    initial begin
        // ---------------- reset ----------------
        rst_n = 1'b0;
        tick();
        tick();
        check("reset res_valid", 32'(res_valid), 32'd0);
        check("reset res_s",     32'(res_s),     32'd0);
        check("reset res_c",     32'(res_c),     32'd0);
        check("reset res_z",     32'(res_z),     32'd0);
        check("reset res_err",   32'(res_err),   32'd0);
        check("reset busy",      32'(busy),      32'd0);
        check("reset cmd_ready", 32'(cmd_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // ---------------- bitwise ----------------
        do_op("OR",   OP_OR,  16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1);
        do_op("AND",  OP_AND, 16'h00F0, 16'h0F00, 16'h0000, 1'b0, 1'b1, 1'b0, 1);
        do_op("XOR",  OP_XOR, 16'h00F0, 16'h0FF0, 16'h0F00, 1'b0, 1'b0, 1'b0, 1);

        // ---------------- add / sub ----------------
        do_op("ADD",  OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1);
        do_op("SUB35",OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1);
        do_op("SUB53",OP_SUB, 16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0, 1'b0, 1);

        // ---------------- multiply ----------------
        // 0x12 * 0x34 = 18 * 52 = 936 = 0x03A8
        do_op("MUL",  OP_MUL, 16'h0012, 16'h0034, 16'h03A8, 1'b0, 1'b0, 1'b0, 17);
        // 0x100 * 0x100 = 0x10000: low half zero, high half nonzero
        do_op("MULOV",OP_MUL, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1, 1'b0, 17);

        // ---------------- shift left ----------------
        // last bit shifted out of 0x4000 is 0
        do_op("SHL15",OP_SHL, 16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b0, 1'b0, 16);
        do_op("SHL1", OP_SHL, 16'h8001, 16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0, 2);
        do_op("SHL0", OP_SHL, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0, 1);

        // ---------------- backpressure ----------------
        start("BP_ADD", OP_ADD, 16'h1234, 16'h1111);
        finish_op("BP_ADD", 16'h2345, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        cmd_op    = OP_XOR;
        cmd_a     = 16'hAAAA;
        cmd_b     = 16'h5555;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("BP hold res_valid", 32'(res_valid), 32'd1);
            check("BP hold res_s",     32'(res_s),     32'h2345);
            check("BP hold cmd_ready", 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("BP take cmd_ready", 32'(cmd_ready), 32'd1);
        check("BP take res_valid", 32'(res_valid), 32'd0);
        check("BP take busy",      32'(busy),      32'd0);
        tick();
        check("BP no stray accept busy", 32'(busy), 32'd0);
        check("BP no stray accept res_s", 32'(res_s), 32'h2345);
        $display("TXN %-10s held 5 cycles, stray command ignored", "BP");

        // ---------------- reset mid-MUL ----------------
        start("RSTMUL", OP_MUL, 16'h0012, 16'h0034);
        for (int i = 0; i < 9; i++) tick();
        check("RSTMUL busy_before_reset", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("RSTMUL res_valid", 32'(res_valid), 32'd0);
        check("RSTMUL res_s",     32'(res_s),     32'd0);
        check("RSTMUL res_c",     32'(res_c),     32'd0);
        check("RSTMUL res_z",     32'(res_z),     32'd0);
        check("RSTMUL res_err",   32'(res_err),   32'd0);
        check("RSTMUL busy",      32'(busy),      32'd0);
        check("RSTMUL cmd_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 20; i++) tick();
        check("RSTMUL no late result", 32'(res_valid), 32'd0);
        $display("TXN %-10s aborted at iteration 8", "RSTMUL");

        do_op("OR2",  OP_OR,  16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 1'b0, 1);
        do_op("RSV",  OP_RSV, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
